stack_ctrl: RTL and testbench

//  Sequences the SP stack-pointer register and the data-memory port to execute PUSH, POP and LOAD-SP requests.

---
 rtl/stack_ctrl_pkg.sv | 30 +++
 rtl/stack_bounds_chk.sv | 29 ++
 rtl/stack_ctrl.sv | 146 ++++++++++++++
 tb/tb_stack_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack controller: request op codes, SP drive codes and FSM states.
// Imported by stack_ctrl, stack_bounds_chk, the control unit and the SP instance.
package stack_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_PUSH = 2'b00,
      OP_POP  = 2'b01,
      OP_LOAD = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SP_HOLD = 2'b00,
      SP_INC  = 2'b01,
      SP_DEC  = 2'b10,
      SP_LOAD = 2'b11
   } sp_drive_e;

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_PUSH_DEC,
      S_PUSH_WR,
      S_POP_RD,
      S_POP_INC,
      S_LOAD,
      S_RESP
   } state_e;

endpackage

// File: rtl/stack_bounds_chk.sv
// Combinational stack bounds check: overflow on full PUSH, underflow on empty POP,
// and out-of-range LOAD values. Only instantiated when STACK_CTRL_BOUNDS_EN is defined.
module stack_bounds_chk
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned          DATA_W      = 32,
   parameter logic [DATA_W-1:0]    STACK_BASE  = 32'h0000_1000,
   parameter int unsigned          STACK_DEPTH = 256
) (
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] sp,
   input  logic [DATA_W-1:0] value,
   output logic              fault
);

   // Lowest legal SP: stack full-descending from STACK_BASE.
   localparam logic [DATA_W-1:0] SP_FULL = STACK_BASE - DATA_W'(STACK_DEPTH);

   always_comb begin
      fault = 1'b0;
      unique case (op_e'(op))
         OP_PUSH: fault = (sp == SP_FULL);
         OP_POP:  fault = (sp == STACK_BASE);
         OP_LOAD: fault = (value < SP_FULL) || (value > STACK_BASE);
         OP_NOP:  fault = 1'b0;
      endcase
   end

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: sequences the external SP register and the data-memory port for
// PUSH/POP/LOAD-SP requests. Optional bounds checking under STACK_CTRL_BOUNDS_EN.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned          DATA_W      = 32,
   parameter logic [DATA_W-1:0]    STACK_BASE  = 32'h0000_1000,
   parameter int unsigned          STACK_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_fault,
   output logic [1:0]        SPDrive,
   output logic [DATA_W-1:0] SPSet,
   input  logic [DATA_W-1:0] SPOutput,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rdata_q;
   logic              fault_q;
   logic              fault;
   logic              accept;

   assign accept = (state_q == S_IDLE) && req_valid;

`ifdef STACK_CTRL_BOUNDS_EN
   stack_bounds_chk #(
      .DATA_W      (DATA_W),
      .STACK_BASE  (STACK_BASE),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_bounds (
      .op    (req_op),
      .sp    (SPOutput),
      .value (req_data),
      .fault (fault)
   );
`else
   assign fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         op_q    <= OP_PUSH;
         data_q  <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= op_e'(req_op);
            data_q  <= req_data;
            fault_q <= fault;
         end
         if ((state_q == S_POP_RD) && mem_ack) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_INIT:     state_d = S_IDLE;
         S_IDLE: begin
            if (accept) begin
               if (fault) begin
                  state_d = S_RESP;
               end else begin
                  unique case (op_e'(req_op))
                     OP_PUSH: state_d = S_PUSH_DEC;
                     OP_POP:  state_d = S_POP_RD;
                     OP_LOAD: state_d = S_LOAD;
                     OP_NOP:  state_d = S_RESP;
                  endcase
               end
            end
         end
         S_PUSH_DEC: state_d = S_PUSH_WR;
         S_PUSH_WR:  if (mem_ack) state_d = S_RESP;
         S_POP_RD:   if (mem_ack) state_d = S_POP_INC;
         S_POP_INC:  state_d = S_RESP;
         S_LOAD:     state_d = S_RESP;
         S_RESP:     state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from state but forced quiet while rst is high, so strobes and
   // SPDrive drop at the very edge that samples reset.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_fault = 1'b0;
      SPDrive   = SP_HOLD;
      SPSet     = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_INIT: begin
               SPDrive = SP_LOAD;
               SPSet   = STACK_BASE;
            end
            S_IDLE:     req_ready = 1'b1;
            S_PUSH_DEC: SPDrive = SP_DEC;
            S_PUSH_WR: begin
               mem_addr  = SPOutput;
               mem_wdata = data_q;
               mem_we    = 1'b1;
            end
            S_POP_RD: begin
               mem_addr = SPOutput;
               mem_re   = 1'b1;
            end
            S_POP_INC:  SPDrive = SP_INC;
            S_LOAD: begin
               SPDrive = SP_LOAD;
               SPSet   = data_q;
            end
            S_RESP: begin
               rsp_valid = 1'b1;
               rsp_fault = fault_q;
               rsp_data  = ((op_q == OP_POP) && !fault_q) ? rdata_q : SPOutput;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: SP register model + memory model with programmable ack delay,
// stack reference model feeding a scoreboard that a monitor drains on rsp_valid.
module tb_stack_ctrl;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_data;
   logic        rsp_valid, rsp_fault;
   logic [31:0] rsp_data;
   logic [1:0]  SPDrive;
   logic [31:0] SPSet, SPOutput;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_re, mem_ack;

   always #5 clk = ~clk;

   stack_ctrl #(
      .DATA_W      (32),
      .STACK_BASE  (BASE),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_fault (rsp_fault),
      .SPDrive   (SPDrive),
      .SPSet     (SPSet),
      .SPOutput  (SPOutput),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   // SP register instance
   always @(posedge clk) begin
      if (rst) SPOutput <= 32'h0;
      else begin
         case (SPDrive)
            2'b01:   SPOutput <= SPOutput + 32'd1;
            2'b10:   SPOutput <= SPOutput - 32'd1;
            2'b11:   SPOutput <= SPSet;
            default: SPOutput <= SPOutput;
         endcase
      end
   end

   // Memory model: ack after mem_delay extra strobe cycles
   logic [31:0] tb_mem [0:8191];
   int ack_cnt = 0;
   int mem_delay = 0;
   int re_cycles = 0;
   assign mem_ack   = (mem_we || mem_re) && (ack_cnt == mem_delay);
   assign mem_rdata = tb_mem[mem_addr[12:0]];
   always @(posedge clk) begin
      if ((mem_we || mem_re) && !mem_ack) ack_cnt <= ack_cnt + 1;
      else ack_cnt <= 0;
      if (mem_we && mem_ack) tb_mem[mem_addr[12:0]] <= mem_wdata;
      if (mem_re) re_cycles <= re_cycles + 1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: abstract stack = SP value + sparse word memory
   typedef struct {
      logic [31:0] data;
      logic        fault;
      logic [31:0] sp;
      int          due;
   } exp_t;
   exp_t sb[$];
   logic [31:0] m_sp;
   logic [31:0] ref_mem [logic [31:0]];

   task automatic model(input logic [1:0] op, input logic [31:0] data, input int d,
                        output exp_t e);
      logic flt = 1'b0;
`ifdef STACK_CTRL_BOUNDS_EN
      if (op == 2'b00 && m_sp == BASE - DEPTH) flt = 1'b1;
      if (op == 2'b01 && m_sp == BASE) flt = 1'b1;
      if (op == 2'b10 && (data < BASE - DEPTH || data > BASE)) flt = 1'b1;
`endif
      e.fault = flt;
      if (flt) begin
         e.data = m_sp;
         e.due  = 0;
      end else begin
         case (op)
            2'b00: begin
               m_sp = m_sp - 1;
               ref_mem[m_sp] = data;
               e.data = m_sp;
               e.due  = 2 + d;
            end
            2'b01: begin
               e.data = ref_mem.exists(m_sp) ? ref_mem[m_sp] : 32'h0;
               m_sp = m_sp + 1;
               e.due = 2 + d;
            end
            2'b10: begin
               m_sp = data;
               e.data = m_sp;
               e.due  = 1;
            end
            default: begin
               e.data = m_sp;
               e.due  = 0;
            end
         endcase
      end
      e.sp = m_sp;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] data, input int d);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
      end else begin
         mem_delay = d;
         req_valid = 1'b1;
         req_op    = op;
         req_data  = data;
         model(op, data, d, e);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         e.due = e.due + cyc;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", sb.size(), 32'h0);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", {31'h0, rsp_valid}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
            chk("sp_after", SPOutput, e.sp);
            chk("latency", cyc, e.due);
         end
      end
   end

   initial begin
      int r, n;
      int re0;
      logic [1:0] op;
      logic [31:0] v;
      for (int i = 0; i < 8192; i++) tb_mem[i] = 32'h0;
      tb_mem[13'h1000] = 32'h0000_A5A5;
      ref_mem[32'h1000] = 32'h0000_A5A5;
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 2'b00;
      req_data = 32'h0;
      m_sp = BASE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_spdrive", {30'h0, SPDrive}, 32'h0);
      chk("rst_strobes", {30'h0, mem_we, mem_re}, 32'h0);
      chk("rst_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("rst_sp", SPOutput, 32'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("init_sp", SPOutput, BASE);
      chk("idle_ready", {31'h0, req_ready}, 32'h1);

      issue(2'b00, 32'd5791, 0);
      issue(2'b00, 32'd7894, 0);
      drain();
      chk("mem_fff", tb_mem[13'h0FFF], 32'd5791);
      chk("mem_ffe", tb_mem[13'h0FFE], 32'd7894);
      issue(2'b01, 32'h0, 3);
      issue(2'b01, 32'h0, 3);
      issue(2'b10, 32'h0F80, 0);
      issue(2'b11, 32'h0, 0);
      issue(2'b10, BASE, 0);
      drain();

`ifdef STACK_CTRL_BOUNDS_EN
      re0 = re_cycles;
      issue(2'b01, 32'h0, 0);
      drain();
      chk("empty_pop_no_re", re_cycles - re0, 32'h0);
      for (int i = 0; i < DEPTH + 1; i++) issue(2'b00, 32'h100 + i, 0);
      drain();
      chk("full_sp", SPOutput, 32'h0F00);
      issue(2'b10, 32'h0EFF, 0);
      issue(2'b10, 32'h1001, 0);
      issue(2'b10, BASE, 0);
      drain();
`else
      issue(2'b01, 32'h0, 1);
      drain();
      chk("wrap_sp", SPOutput, 32'h1001);
      issue(2'b10, BASE, 0);
      drain();
`endif

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 99);
         op = (r < 40) ? 2'b00 : (r < 75) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
         if (op == 2'b10) begin
            if ($urandom_range(0, 3) == 0) v = BASE + $urandom_range(1, 10);
            else v = BASE - $urandom_range(0, 300);
         end else begin
            v = $urandom;
         end
         issue(op, v, $urandom_range(0, 4));
      end
      drain();

      // Reset during PUSH_WR with ack withheld
      issue(2'b10, BASE, 0);
      drain();
      @(negedge clk);
      mem_delay = 100000;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_data  = 32'hDEAD;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!mem_we && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_we_seen", {31'h0, mem_we}, 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_we_drop", {31'h0, mem_we}, 32'h0);
      chk("abort_spdrive", {30'h0, SPDrive}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_sp = BASE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("abort_sp", SPOutput, BASE);
      chk("abort_ready", {31'h0, req_ready}, 32'h1);
      chk("abort_no_write", tb_mem[13'h0FFF] === 32'hDEAD ? 32'h1 : 32'h0, 32'h0);
      issue(2'b11, 32'h0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
